// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty-cycle measurement block.
// PWM_GLITCH_FILT_EN enables the input glitch filter in pwm_in_cond.
package pwm_pkg;

    localparam int PWM_DUTY_W      = 11;
    localparam int PWM_PERIOD      = 2048;
    localparam int PWM_TIMEOUT     = 3072;
    localparam int PWM_CNT_W       = 12;
    localparam int PWM_SYNC_STAGES = 2;
    localparam int PWM_FILT_LEN    = 4;

    typedef logic [PWM_DUTY_W-1:0] duty_t;

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        STUCK_HI,
        STUCK_LO,
        WAIT
    } meas_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning: synchronizer, optional glitch filter, registered edge detect.
// Glitch filter is built when PWM_GLITCH_FILT_EN is defined.
import pwm_pkg::*;

module pwm_in_cond #(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

`ifdef PWM_GLITCH_FILT_EN
    localparam int FILT_LAT = PWM_FILT_LEN;
`else
    localparam int FILT_LAT = 0;
`endif
    localparam int WARM = SYNC_STAGES + FILT_LAT + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic [WARM-1:0]        warm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_GLITCH_FILT_EN
    logic       filt;
    logic [1:0] filt_cnt;

    // Level follows the synchronized input only after it has differed for PWM_FILT_LEN cycles in a row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt     <= 1'b0;
            filt_cnt <= 2'd0;
        end else if (sync[SYNC_STAGES-1] == filt) begin
            filt_cnt <= 2'd0;
        end else if (filt_cnt == 2'(PWM_FILT_LEN - 1)) begin
            filt     <= sync[SYNC_STAGES-1];
            filt_cnt <= 2'd0;
        end else begin
            filt_cnt <= filt_cnt + 2'd1;
        end
    end

    assign s = filt;
`else
    assign s = sync[SYNC_STAGES-1];
`endif

    // Edges are suppressed until the pipeline holds real samples, so a line
    // already high at reset release does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_d  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            warm <= '0;
        end else begin
            warm <= {warm[WARM-2:0], 1'b1};
            s_d  <= s;
            rise <= s & ~s_d & warm[WARM-1];
            fall <= ~s & s_d & warm[WARM-1];
        end
    end

    assign level = s_d;

endmodule

// File: rtl/pwm_duty_meas.sv
// Measures high time and period of a PWM input and reports the duty word
// plus period-error and stuck flags. Optional glitch filter: PWM_GLITCH_FILT_EN.
import pwm_pkg::*;

module pwm_duty_meas #(
    parameter int DUTY_W      = PWM_DUTY_W,
    parameter int CNT_W       = PWM_CNT_W,
    parameter int TIMEOUT     = PWM_TIMEOUT,
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              duty_vld,
    output logic              period_err,
    output logic              stuck_hi,
    output logic              stuck_lo,
    output logic [2:0]        fsm_state
);

    localparam logic [CNT_W-1:0] DUTY_MAX   = CNT_W'(2**DUTY_W - 1);
    localparam logic [CNT_W-1:0] PERIOD_NOM = CNT_W'(2**DUTY_W);
    localparam logic [CNT_W-1:0] TMO        = CNT_W'(TIMEOUT);

    logic level;
    logic rise;
    logic fall;

    pwm_in_cond #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_in_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    meas_state_t       state;
    meas_state_t       state_nxt;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  lo_cnt;
    logic [CNT_W-1:0]  hi_nxt;
    logic [CNT_W-1:0]  lo_nxt;
    logic [CNT_W-1:0]  hi_inc;
    logic [CNT_W-1:0]  lo_inc;
    logic [CNT_W-1:0]  hi_m1;
    logic [CNT_W:0]    period_sum;
    logic [CNT_W-1:0]  period_calc;
    logic [DUTY_W-1:0] duty_calc;
    logic [DUTY_W-1:0] duty_nxt;
    logic [CNT_W-1:0]  period_nxt;
    logic              err_nxt;
    logic              shi_nxt;
    logic              slo_nxt;
    logic              vld_nxt;

    // Counters include the cycle on which the closing edge is seen, so hi_cnt is
    // exactly the high time and lo_inc the low time when the next rise lands.
    assign hi_inc      = (&hi_cnt) ? hi_cnt : hi_cnt + CNT_W'(1);
    assign lo_inc      = (&lo_cnt) ? lo_cnt : lo_cnt + CNT_W'(1);
    assign hi_m1       = hi_cnt - CNT_W'(1);
    assign duty_calc   = (hi_m1 > DUTY_MAX) ? '1 : hi_m1[DUTY_W-1:0];
    assign period_sum  = {1'b0, hi_cnt} + {1'b0, lo_inc};
    assign period_calc = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];

    always_comb begin
        state_nxt  = state;
        hi_nxt     = hi_cnt;
        lo_nxt     = lo_cnt;
        duty_nxt   = duty;
        period_nxt = period;
        err_nxt    = period_err;
        shi_nxt    = stuck_hi;
        slo_nxt    = stuck_lo;
        vld_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = HIGH;
                    hi_nxt    = '0;
                end
            end
            HIGH: begin
                hi_nxt = hi_inc;
                if (fall) begin
                    state_nxt = LOW;
                    lo_nxt    = '0;
                end else if (level && hi_inc == TMO) begin
                    state_nxt = STUCK_HI;
                    duty_nxt  = '1;
                    shi_nxt   = 1'b1;
                    slo_nxt   = 1'b0;
                    vld_nxt   = 1'b1;
                end
            end
            LOW: begin
                lo_nxt = lo_inc;
                if (rise) begin
                    state_nxt  = HIGH;
                    hi_nxt     = '0;
                    duty_nxt   = duty_calc;
                    period_nxt = period_calc;
                    err_nxt    = (period_calc != PERIOD_NOM);
                    shi_nxt    = 1'b0;
                    slo_nxt    = 1'b0;
                    vld_nxt    = 1'b1;
                end else if (!level && lo_inc == TMO) begin
                    state_nxt = STUCK_LO;
                    duty_nxt  = '0;
                    shi_nxt   = 1'b0;
                    slo_nxt   = 1'b1;
                    vld_nxt   = 1'b1;
                end
            end
            STUCK_HI: begin
                // High time before this fall is unknown; skip the next period.
                if (fall) begin
                    state_nxt = WAIT;
                    shi_nxt   = 1'b0;
                end
            end
            STUCK_LO: begin
                if (rise) begin
                    state_nxt = HIGH;
                    hi_nxt    = '0;
                    slo_nxt   = 1'b0;
                end
            end
            WAIT: begin
                if (rise) begin
                    state_nxt = HIGH;
                    hi_nxt    = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            duty       <= '0;
            period     <= '0;
            period_err <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
            duty_vld   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hi_cnt     <= hi_nxt;
            lo_cnt     <= lo_nxt;
            duty       <= duty_nxt;
            period     <= period_nxt;
            period_err <= err_nxt;
            stuck_hi   <= shi_nxt;
            stuck_lo   <= slo_nxt;
            duty_vld   <= vld_nxt;
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Directed bench for pwm_duty_meas: PWM waveforms with hand-computed duty/period results.
// Expectations follow PWM_GLITCH_FILT_EN when it is defined for the build.
import pwm_pkg::*;

module tb_pwm_duty_meas;

`ifdef PWM_GLITCH_FILT_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic        pwm_in;
    logic [10:0] duty;
    logic [11:0] period;
    logic        duty_vld;
    logic        period_err;
    logic        stuck_hi;
    logic        stuck_lo;
    logic [2:0]  fsm_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic prev_vld = 1'b0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];
    string       tag_q[$];

    pwm_duty_meas dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .duty      (duty),
        .period    (period),
        .duty_vld  (duty_vld),
        .period_err(period_err),
        .stuck_hi  (stuck_hi),
        .stuck_lo  (stuck_lo),
        .fsm_state (fsm_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_vld(input string tag, input int d, input int p,
                              input logic e, input logic sh, input logic sl, input int at_cyc);
        exp_q.push_back(32'({11'(d), 12'(p), e, sh, sl}));
        cyc_q.push_back(at_cyc);
        tag_q.push_back(tag);
    endtask

    // driver: called at a falling edge; level is sampled on the next n rising edges
    task automatic drive(input logic v, input int n);
        pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int h, input int l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_duty"}, 32'(duty), 32'd0);
        check({tag, "_period"}, 32'(period), 32'd0);
        check({tag, "_vld"}, 32'(duty_vld), 32'd0);
        check({tag, "_err"}, 32'(period_err), 32'd0);
        check({tag, "_shi"}, 32'(stuck_hi), 32'd0);
        check({tag, "_slo"}, 32'(stuck_lo), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
    endtask

    // scoreboard: every duty_vld pulse is matched against the next expected entry
    always @(negedge clk) begin
        if (duty_vld) begin
            check("vld_gap", 32'(prev_vld), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_vld", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                automatic string       t  = tag_q.pop_front();
                automatic logic [31:0] e  = exp_q.pop_front();
                automatic int          ec = cyc_q.pop_front();
                check(t, 32'({duty, period, period_err, stuck_hi, stuck_lo}), e);
                check({t, "_cyc"}, 32'(cyc), 32'(ec));
            end
        end
        prev_vld <= duty_vld;
    end

    initial begin
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        drive(1'b0, 12);

        // nominal 1025 high / 1023 low; first rise from IDLE reports nothing
        pulse(1025, 1023);
        for (int i = 0; i < 3; i++) begin
            expect_vld("per_0x400", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
            pulse(1025, 1023);
        end
`ifndef PWM_GLITCH_FILT_EN
        expect_vld("per_0x400", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        pulse(1, 2047);
        expect_vld("duty_zero", 0, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        pulse(1, 2047);
        expect_vld("duty_zero", 0, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        pulse(300, 700);
`else
        expect_vld("per_0x400", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        pulse(300, 700);
`endif
        expect_vld("short_period", 299, 1000, 1'b1, 1'b0, 1'b0, cyc + 1 + LAT);
        pulse(300, 700);

        // stuck high from a running period; period/err keep the last measurement
        expect_vld("short_period", 299, 1000, 1'b1, 1'b0, 1'b0, cyc + 1 + LAT);
        expect_vld("stuck_hi", 'h7FF, 1000, 1'b1, 1'b1, 1'b0, cyc + 1 + LAT + 3072);
        drive(1'b1, 3122);
        check("stuck_hi_held", 32'(stuck_hi), 32'd1);
        drive(1'b0, 12);
        check("stuck_hi_clear", 32'(stuck_hi), 32'd0);
        drive(1'b0, 488);
        drive(1'b1, 600);
        drive(1'b0, 1448);
        expect_vld("after_wait", 599, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        drive(1'b1, 1025);

        // stuck low
        expect_vld("stuck_lo", 0, 2048, 1'b0, 1'b0, 1'b1, cyc + 1 + LAT + 3072);
        drive(1'b0, 3200);
        check("stuck_lo_held", 32'(stuck_lo), 32'd1);
        drive(1'b1, 12);
        check("stuck_lo_clear", 32'(stuck_lo), 32'd0);
        drive(1'b1, 1013);
        drive(1'b0, 1023);
        expect_vld("resume", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
        drive(1'b1, 500);

        // one-cycle reset in the middle of a high phase
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("mid_reset");
        rst_n = 1'b1;
        drive(1'b1, 525);
        drive(1'b0, 1023);
        pulse(1025, 1023);
        expect_vld("post_reset", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);

        // 2-cycle low glitch inside a 1025-cycle high phase
        drive(1'b1, 600);
        drive(1'b0, 2);
`ifndef PWM_GLITCH_FILT_EN
        expect_vld("glitch_split", 599, 602, 1'b1, 1'b0, 1'b0, cyc + 1 + LAT);
`endif
        drive(1'b1, 423);
        drive(1'b0, 1023);
`ifdef PWM_GLITCH_FILT_EN
        expect_vld("glitch_ignored", 'h400, 2048, 1'b0, 1'b0, 1'b0, cyc + 1 + LAT);
`else
        expect_vld("glitch_tail", 422, 1446, 1'b1, 1'b0, 1'b0, cyc + 1 + LAT);
`endif
        drive(1'b1, 100);
        drive(1'b0, 20);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
